fetch_prefetch_queue: RTL and testbench

Parametrised successor to the fixed single-instruction fetch stage: decouples instruction fetch from decode through a DEPTH-entry prefetch queue and a pipelined request/response instruction-memory handshake. It sits between the instruction memory and the IF/DEC pipeline register, issuing up to MAX_OUT outstanding reads. Branch/jump redirects from execute flush the queue and discard in-flight responses in order.

---
 rtl/fetch_prefetch_queue_pkg.sv | 14 +
 rtl/fetch_prefetch_queue_fifo_sync.sv | 57 +++++
 rtl/fetch_prefetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// rtl/fetch_prefetch_queue_pkg.sv - shared constants for the prefetching fetch stage
package fetch_prefetch_queue_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam int          ENTRY_W_DEF  = 2 * XLEN_DEF;

  // Queue entries carry {pc, instruction}
  function automatic int entry_width(input int xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo_sync.sv
// rtl/fetch_prefetch_queue_fifo_sync.sv - synchronous FIFO with clear, count, full/empty
module fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(push_i && full_o));
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - fetch stage with prefetch queue and pipelined imem handshake
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus_4,
  output logic [XLEN-1:0] if_instr,
  output logic            proto_err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = entry_width(XLEN);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [OW-1:0]   outstanding_q, outstanding_d, drop_q, drop_d;
  logic            proto_err_q, proto_err_d;
  logic [CW-1:0]   q_count;
  logic            q_full, q_empty;
  logic [EW-1:0]   q_head;
  logic            req_fire, rsp_fire, rsp_push, pop;
  int              credit_used;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  // Credits count queued entries plus in-flight responses that will be kept
  always_comb begin
    credit_used    = int'(q_count) + int'(outstanding_q) - int'(drop_q);
    imem_req_valid = rst && !redirect_valid && (int'(outstanding_q) < MAX_OUT)
                     && (credit_used < DEPTH);
  end

  assign imem_req_addr = fetch_pc_q;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_fire      = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_push      = rsp_fire && (drop_q == '0) && !redirect_valid;
  assign if_valid      = !q_empty && !redirect_valid;
  assign pop           = if_valid && if_ready;

  assign if_pc        = q_empty ? '0 : q_head[EW-1:XLEN];
  assign if_instr     = q_empty ? '0 : q_head[XLEN-1:0];
  assign if_pc_plus_4 = q_empty ? '0 : q_head[EW-1:XLEN] + XLEN'(4);
  assign proto_err    = proto_err_q;

  always_comb begin
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_fire);
    proto_err_d   = proto_err_q | (imem_rsp_valid && (outstanding_q == '0));
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_d     = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_push) rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      proto_err_q   <= proto_err_d;
    end
  end

  fifo_sync #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect_valid),
    .push_i  (rsp_push),
    .data_i  ({rsp_pc_q, imem_rsp_data}),
    .pop_i   (pop),
    .data_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - scoreboard bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  logic        clk, rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_pc_plus_4, if_instr;
  logic        proto_err;

  fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus_4   (if_pc_plus_4),
    .if_instr       (if_instr),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; int due; } mreq_t;

  int          n_vec, n_err, cyc, lat, fires, pops;
  bit          inject, prev_stall;
  logic [31:0] prev_addr, exp_fetch;
  logic [31:0] sb_q[$];
  logic [31:0] popped[$];
  mreq_t       mem_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: drive memory, observe handshakes before the edge, update model
  task automatic step();
    logic [31:0] e;
    if (inject) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (prev_stall && !redirect_valid) begin
      check("req_hold_valid", 64'(imem_req_valid), 64'(1));
      check("req_hold_addr", 64'(imem_req_addr), 64'(prev_addr));
    end
    if (imem_rsp_valid && !inject) void'(mem_q.pop_front());
    if (redirect_valid) begin
      check("redirect_no_pop", 64'(if_valid), 64'(0));
      check("redirect_no_req", 64'(imem_req_valid), 64'(0));
      sb_q.delete();
      exp_fetch = redirect_pc & ~32'h3;
    end
    if (if_valid && if_ready) begin
      pops++;
      if (sb_q.size() == 0) begin
        check("pop_expected", 64'(sb_q.size()), 64'(1));
      end else begin
        e = sb_q.pop_front();
        popped.push_back(if_pc);
        check("if_pc", 64'(if_pc), 64'(e));
        check("if_instr", 64'(if_instr), 64'(mem_data(e)));
        check("if_pc_plus_4", 64'(if_pc_plus_4), 64'(e + 32'd4));
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      fires++;
      check("req_addr", 64'(imem_req_addr), 64'(exp_fetch));
      mem_q.push_back('{addr: exp_fetch, due: cyc + lat});
      sb_q.push_back(exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr  = imem_req_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid), 64'(0));
    check({tag, "_if_valid"}, 64'(if_valid), 64'(0));
    check({tag, "_if_pc"}, 64'(if_pc), 64'(0));
    check({tag, "_if_instr"}, 64'(if_instr), 64'(0));
    check({tag, "_if_pc_plus_4"}, 64'(if_pc_plus_4), 64'(0));
    check({tag, "_proto_err"}, 64'(proto_err), 64'(0));
  endtask

  task automatic model_reset();
    mem_q.delete();
    sb_q.delete();
    exp_fetch      = 32'h0;
    prev_stall     = 1'b0;
    inject         = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  endtask

  initial begin
    int first, f0, p0, n;
    n_vec = 0; n_err = 0; cyc = 0; lat = 1; fires = 0; pops = 0;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    model_reset();
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Streaming from reset with 1-cycle memory
    first = 0;
    for (int k = 1; k <= 10 && first == 0; k++) begin
      if (if_valid) first = k;
      step();
    end
    check("first_valid_cycle", 64'(first), 64'(3));
    check("first_pc", 64'(popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF), 64'(0));
    p0 = pops;
    for (int k = 0; k < 8; k++) step();
    check("stream_rate", 64'(pops - p0), 64'(8));

    // Decode stall: credits cap requests at DEPTH
    if_ready = 1'b0;
    redirect(32'h0);
    f0 = fires;
    for (int k = 0; k < 10; k++) step();
    check("stall_fires", 64'(fires - f0), 64'(4));
    check("stall_req_valid", 64'(imem_req_valid), 64'(0));
    if_ready = 1'b1;
    p0 = pops;
    popped.delete();
    for (int k = 0; k < 4; k++) step();
    check("stall_drain_pops", 64'(pops - p0), 64'(4));
    check("stall_pc3", 64'(popped.size() == 4 ? popped[3] : 32'hFFFF_FFFF), 64'(32'hC));

    // Redirect with two in flight on a 3-cycle memory
    lat = 3;
    for (int k = 0; k < 10; k++) step();
    redirect(32'h100);
    popped.delete();
    for (int k = 0; k < 20 && popped.size() < 2; k++) step();
    check("redir_pc0", 64'(popped.size() >= 1 ? popped[0] : 32'hFFFF_FFFF), 64'(32'h100));
    check("redir_pc1", 64'(popped.size() >= 2 ? popped[1] : 32'hFFFF_FFFF), 64'(32'h104));

    // Unaligned redirect coinciding with a response and a pending pop
    lat = 1;
    for (int k = 0; k < 6; k++) step();
    check("pre_redirect_valid", 64'(if_valid), 64'(1));
    redirect(32'h203);
    check("aligned_addr", 64'(imem_req_addr), 64'(32'h200));
    check("flushed_empty", 64'(if_valid), 64'(0));
    n = 0;
    while (!if_valid && n < 10) begin step(); n++; end
    check("redirect_latency", 64'(n), 64'(2));

    // Random request backpressure and decode stalls
    lat = 2;
    for (int k = 0; k < 200; k++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      if_ready       = 1'($urandom_range(0, 1));
      step();
    end

    // Response with nothing outstanding
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    n = 0;
    while (mem_q.size() > 0 && n < 20) begin step(); n++; end
    check("drain_bound", 64'(mem_q.size()), 64'(0));
    for (int k = 0; k < 6; k++) step();
    check("proto_before", 64'(proto_err), 64'(0));
    inject = 1'b1;
    step();
    inject = 1'b0;
    check("proto_set", 64'(proto_err), 64'(1));
    for (int k = 0; k < 3; k++) step();
    check("proto_sticky", 64'(proto_err), 64'(1));
    check("proto_no_push", 64'(if_valid), 64'(0));

    // Asynchronous reset mid-burst
    imem_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    popped.delete();
    for (int k = 0; k < 8; k++) step();
    check("post_rst_pc0", 64'(popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
